// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM with programmable wait states,
// byte-strobed writes, size/alignment/range ERROR responses and read-after-write forwarding.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    hclk,
  input  logic                    hrst,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hstrb,
  input  logic                    hready,
  output logic                    hready_out,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LB    = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  dp_valid;
  logic                  dp_write;
  logic [IDX_W-1:0]      dp_idx;
  logic [BYTES-1:0]      dp_lanes;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  addr_err;
  logic                  commit;
  logic [IDX_W-1:0]      a_idx;
  logic [BYTES-1:0]      a_lanes;
  logic [BYTES-1:0]      wr_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  assign unused_ok = ^{hburst, htrans[0]};
  assign accept    = hsel & hready & htrans[1] & hready_out;
  assign a_idx     = haddr[LB +: IDX_W];
  assign commit    = (state == S_IDLE) & dp_valid & dp_write;

  always_comb begin
    addr_err = 1'b0;
    if (32'(hsize) > LB)
      addr_err = 1'b1;
    if ((haddr & ((ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1))) != '0)
      addr_err = 1'b1;
    if ((haddr >> LB) >= ADDR_WIDTH'(MEM_DEPTH))
      addr_err = 1'b1;
    a_lanes = '0;
    for (int unsigned i = 0; i < BYTES; i++)
      if (i >= 32'(haddr[LB-1:0]) && i < 32'(haddr[LB-1:0]) + (32'd1 << hsize))
        a_lanes[i] = 1'b1;
  end

  // Merged post-write word; a read accepted on the commit edge of the same word sees it.
  always_comb begin
    wr_mask = dp_lanes & hstrb;
    wr_word = mem[dp_idx];
    for (int unsigned i = 0; i < BYTES; i++)
      if (wr_mask[i])
        wr_word[8*i +: 8] = hwdata[8*i +: 8];
    rd_word = (commit && dp_idx == a_idx) ? wr_word : mem[a_idx];
  end

  always_ff @(posedge hclk) begin
    if (commit)
      for (int unsigned i = 0; i < BYTES; i++)
        if (wr_mask[i])
          mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state      <= S_IDLE;
      hready_out <= 1'b1;
      hresp      <= 1'b0;
      hrdata     <= '0;
      wait_cnt   <= '0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_idx     <= '0;
      dp_lanes   <= '0;
    end else begin
      hrdata <= '0;
      case (state)
        S_IDLE, S_ERR2: begin
          state      <= S_IDLE;
          hready_out <= 1'b1;
          hresp      <= 1'b0;
          dp_valid   <= 1'b0;
          if (accept) begin
            dp_write <= hwrite;
            dp_idx   <= a_idx;
            dp_lanes <= a_lanes;
            if (addr_err) begin
              state      <= S_ERR1;
              hready_out <= 1'b0;
              hresp      <= 1'b1;
            end else begin
              dp_valid <= 1'b1;
              if (WAIT_STATES > 0) begin
                state      <= S_WAIT;
                hready_out <= 1'b0;
                wait_cnt   <= 4'(WAIT_STATES - 1);
              end else if (!hwrite) begin
                hrdata <= rd_word;
              end
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state      <= S_IDLE;
            hready_out <= 1'b1;
            if (!dp_write)
              hrdata <= mem[dp_idx];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state      <= S_ERR2;
          hready_out <= 1'b1;
          hresp      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances (0, 2 and 3 wait states)
// share one bus; a monitor pops expected responses as data phases complete.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic [2:0]  hsel_v = '0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hstrb = '0;
  logic        stall = 1'b0;
  int          sel = 0;

  logic        hro [3];
  logic        hrs [3];
  logic [31:0] hrd [3];

  logic        m_ready, m_resp, bus_hready, acc_now;
  logic [31:0] m_rdata;

  assign m_ready    = hro[sel];
  assign m_resp     = hrs[sel];
  assign m_rdata    = hrd[sel];
  assign bus_hready = m_ready & ~stall;
  assign acc_now    = hsel_v[sel] & bus_hready & htrans[1] & ~hrst;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_w0 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hstrb(hstrb),
    .hready(hro[0] & ~stall), .hready_out(hro[0]), .hresp(hrs[0]), .hrdata(hrd[0]));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_w2 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hstrb(hstrb),
    .hready(hro[1] & ~stall), .hready_out(hro[1]), .hresp(hrs[1]), .hrdata(hrd[1]));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_w3 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hstrb(hstrb),
    .hready(hro[2] & ~stall), .hready_out(hro[2]), .hresp(hrs[2]), .hrdata(hrd[2]));

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  logic in_dp = 1'b0;
  int   dp_waits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge hclk) begin
    if (hrst) begin
      in_dp    = 1'b0;
      dp_waits = 0;
      sb_q.delete();
    end else begin
      if (in_dp) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_data_phase");
        end else begin
          mon_e = sb_q[0];
          if (!m_ready) begin
            dp_waits++;
            check("wait_hrdata", m_rdata, 32'h0);
            check("wait_hresp", 32'(m_resp), 32'(mon_e.err));
          end else begin
            void'(sb_q.pop_front());
            check("hresp", 32'(m_resp), 32'(mon_e.err));
            check("hrdata", m_rdata, (mon_e.rd && !mon_e.err) ? mon_e.rdata : 32'h0);
            check("wait_cycles", dp_waits, mon_e.waits);
            dp_waits = 0;
          end
        end
      end
      in_dp = acc_now || (in_dp && !m_ready);
    end
  end

  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sb,
                      input logic err, input logic [31:0] rd_exp, input int waits);
    exp_t e;
    int   n;
    hsel_v      = '0;
    hsel_v[sel] = 1'b1;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = addr;
    hburst = 3'd1;
    n = 0;
    @(negedge hclk);
    while (!bus_hready && n < 64) begin
      n++;
      @(negedge hclk);
    end
    if (n >= 64) fail_now("accept_timeout");
    @(posedge hclk);
    #1;
    e.err   = err;
    e.rd    = !wr;
    e.rdata = rd_exp;
    e.waits = waits;
    sb_q.push_back(e);
    hwdata = wd;
    hstrb  = sb;
    htrans = 2'd0;
  endtask

  task automatic idle(input int n);
    htrans = 2'd0;
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge hclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_hready_out", 32'(hro[i]), 32'h1);
      check("reset_hresp", 32'(hrs[i]), 32'h0);
      check("reset_hrdata", hrd[i], 32'h0);
    end
    @(negedge hclk);
    hrst = 1'b0;
    idle(2);

    // zero wait states: pipelined write then read of the same word
    sel = 0;
    xfer(2'd2, 1'b1, 3'd2, 32'h0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 0);
    xfer(2'd3, 1'b0, 3'd2, 32'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 0);
    idle(3);

    // sizes and strobes on word 0x8
    xfer(2'd2, 1'b1, 3'd2, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 0);
    xfer(2'd2, 1'b1, 3'd1, 32'hA, 32'hABCD0000, 4'hF, 1'b0, 32'h0, 0);
    xfer(2'd2, 1'b0, 3'd2, 32'h8, 32'h0, 4'h0, 1'b0, 32'hABCDFFFF, 0);
    xfer(2'd2, 1'b1, 3'd0, 32'h8, 32'h00000011, 4'h0, 1'b0, 32'h0, 0);
    xfer(2'd2, 1'b0, 3'd2, 32'h8, 32'h0, 4'h0, 1'b0, 32'hABCDFFFF, 0);
    xfer(2'd2, 1'b1, 3'd0, 32'h9, 32'h00005500, 4'hF, 1'b0, 32'h0, 0);
    xfer(2'd2, 1'b0, 3'd2, 32'h8, 32'h0, 4'h0, 1'b0, 32'hABCD55FF, 0);
    idle(3);

    // error responses; a transfer issued during ERR2 is accepted
    xfer(2'd2, 1'b0, 3'd2, 32'h2, 32'h0, 4'h0, 1'b1, 32'h0, 1);
    xfer(2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 0);
    xfer(2'd2, 1'b1, 3'd2, 32'h1000, 32'h11111111, 4'hF, 1'b1, 32'h0, 1);
    xfer(2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 0);
    xfer(2'd2, 1'b0, 3'd3, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1);
    idle(3);

    // non-accepted cycles: BUSY, stalled bus, deselected
    hsel_v = 3'b001;
    htrans = 2'd1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0;
    hwdata = 32'h0; hstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin htrans = 2'd2; stall = 1'b1; end
      if (k == 2) begin stall = 1'b0; hsel_v = '0; end
      @(negedge hclk);
      check("noacc_hready_out", 32'(m_ready), 32'h1);
      check("noacc_hresp", 32'(m_resp), 32'h0);
      @(posedge hclk);
      #1;
    end
    stall = 1'b0;
    idle(3);
    xfer(2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 0);
    idle(3);

    // two wait states
    sel = 1;
    xfer(2'd2, 1'b1, 3'd2, 32'h4, 32'h12345678, 4'hF, 1'b0, 32'h0, 2);
    xfer(2'd2, 1'b0, 3'd2, 32'h4, 32'h0, 4'h0, 1'b0, 32'h12345678, 2);
    xfer(2'd2, 1'b1, 3'd2, 32'h4, 32'hBEEF0000, 4'b1100, 1'b0, 32'h0, 2);
    xfer(2'd2, 1'b0, 3'd2, 32'h4, 32'h0, 4'h0, 1'b0, 32'hBEEF5678, 2);
    xfer(2'd2, 1'b0, 3'd2, 32'h6, 32'h0, 4'h0, 1'b1, 32'h0, 1);
    idle(6);

    // three wait states, reset in the middle of a write
    sel = 2;
    xfer(2'd2, 1'b1, 3'd2, 32'h10, 32'h01020304, 4'hF, 1'b0, 32'h0, 3);
    xfer(2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0, 1'b0, 32'h01020304, 3);
    idle(6);
    xfer(2'd2, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 3);
    @(negedge hclk);
    @(posedge hclk);
    #2;
    hrst = 1'b1;
    #1;
    check("async_rst_hready_out", 32'(m_ready), 32'h1);
    check("async_rst_hresp", 32'(m_resp), 32'h0);
    check("async_rst_hrdata", m_rdata, 32'h0);
    repeat (2) @(negedge hclk);
    hrst = 1'b0;
    idle(2);
    xfer(2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0, 1'b0, 32'h01020304, 3);
    idle(6);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      n++;
      @(posedge hclk);
    end
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
